// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared types and constants for the TMR vote monitor
package tmr_pkg;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULTY  = 2'd2
  } trk_state_t;

  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;
  localparam int RUN_W  = 8;

endpackage

// File: rtl/tmr_lane_tracker.sv
// rtl/tmr_lane_tracker.sv - per-lane consecutive-mismatch tracker with sticky fault flag
module tmr_lane_tracker
  import tmr_pkg::*;
#(
  parameter int FAULT_THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic mis,
  input  logic clear,
  output logic fault,
  output logic fault_next
);

  localparam logic [RUN_W-1:0] THRESH = RUN_W'(FAULT_THRESH);

  trk_state_t       state, state_n;
  logic [RUN_W-1:0] run, run_n;
  logic [RUN_W-1:0] run_inc;

  assign run_inc = run + RUN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OK;
      run   <= '0;
    end else begin
      state <= state_n;
      run   <= run_n;
    end
  end

  // Invalid cycles fall through untouched so they never break a run.
  always_comb begin
    state_n = state;
    run_n   = run;
    if (clear) begin
      state_n = OK;
      run_n   = '0;
    end else if (valid) begin
      case (state)
        OK: begin
          if (mis) begin
            run_n   = RUN_W'(1);
            state_n = (FAULT_THRESH == 1) ? FAULTY : SUSPECT;
          end
        end
        SUSPECT: begin
          if (mis) begin
            run_n = run_inc;
            if (run_inc == THRESH) state_n = FAULTY;
          end else begin
            state_n = OK;
            run_n   = '0;
          end
        end
        FAULTY: begin
          state_n = FAULTY;
        end
        default: begin
          state_n = OK;
          run_n   = '0;
        end
      endcase
    end
  end

  assign fault      = (state == FAULTY);
  assign fault_next = (state_n == FAULTY);

endmodule

// File: rtl/tmr_vote_monitor.sv
// rtl/tmr_vote_monitor.sv - registered TMR majority voter with mismatch counting and lane health
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int CNT_WIDTH    = 16,
  parameter int FAULT_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic [WIDTH-1:0]     inC,
  input  logic                 in_valid,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic [2:0]           lane_err,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [2:0]           lane_fault,
  output logic                 tmr_lost
);

  logic [WIDTH-1:0] vote;
  logic [2:0]       mis;
  logic [2:0]       fault_next;
  logic             lost_next;

  assign vote = (inA & inB) | (inA & inC) | (inB & inC);

  assign mis[LANE_A] = |(inA ^ vote);
  assign mis[LANE_B] = |(inB ^ vote);
  assign mis[LANE_C] = |(inC ^ vote);

  assign lost_next = (fault_next[0] & fault_next[1]) |
                     (fault_next[0] & fault_next[2]) |
                     (fault_next[1] & fault_next[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      lane_err  <= '0;
      err_count <= '0;
      tmr_lost  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      tmr_lost  <= lost_next;
      if (in_valid) begin
        out      <= vote;
        lane_err <= mis;
      end else begin
        lane_err <= '0;
      end
      // Clear wins over a same-cycle mismatch; the counter saturates at all-ones.
      if (clear) begin
        err_count <= '0;
      end else if (in_valid && (|mis) && (err_count != {CNT_WIDTH{1'b1}})) begin
        err_count <= err_count + CNT_WIDTH'(1);
      end
    end
  end

  tmr_lane_tracker #(.FAULT_THRESH(FAULT_THRESH)) u_trk_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (in_valid),
    .mis        (mis[LANE_A]),
    .clear      (clear),
    .fault      (lane_fault[LANE_A]),
    .fault_next (fault_next[LANE_A])
  );

  tmr_lane_tracker #(.FAULT_THRESH(FAULT_THRESH)) u_trk_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (in_valid),
    .mis        (mis[LANE_B]),
    .clear      (clear),
    .fault      (lane_fault[LANE_B]),
    .fault_next (fault_next[LANE_B])
  );

  tmr_lane_tracker #(.FAULT_THRESH(FAULT_THRESH)) u_trk_c (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (in_valid),
    .mis        (mis[LANE_C]),
    .clear      (clear),
    .fault      (lane_fault[LANE_C]),
    .fault_next (fault_next[LANE_C])
  );

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// tb/tb_tmr_vote_monitor.sv - directed self-checking bench for tmr_vote_monitor
module tb_tmr_vote_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] inA, inB, inC;
  logic       in_valid;
  logic       clear;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] lane_err;
  logic [3:0] err_count;
  logic [2:0] lane_fault;
  logic       tmr_lost;

  int passed = 0;
  int total  = 0;

  tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(4), .FAULT_THRESH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inA        (inA),
    .inB        (inB),
    .inC        (inC),
    .in_valid   (in_valid),
    .clear      (clear),
    .out        (out),
    .out_valid  (out_valid),
    .lane_err   (lane_err),
    .err_count  (err_count),
    .lane_fault (lane_fault),
    .tmr_lost   (tmr_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic v, input logic cl);
    inA = a; inB = b; inC = c; in_valid = v; clear = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"}, 32'(out), 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_lane_err"}, 32'(lane_err), 32'h0);
    chk({tag, "_err_count"}, 32'(err_count), 32'h0);
    chk({tag, "_lane_fault"}, 32'(lane_fault), 32'h0);
    chk({tag, "_tmr_lost"}, 32'(tmr_lost), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; inA = '0; inB = '0; inC = '0; in_valid = 1'b0; clear = 1'b0;
    #2;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // All lanes agree
    step(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0);
    chk("agree_out", 32'(out), 32'hA5);
    chk("agree_valid", 32'(out_valid), 32'h1);
    chk("agree_lane_err", 32'(lane_err), 32'h0);
    chk("agree_err_count", 32'(err_count), 32'h0);

    // Single lane C wrong
    step(8'hA5, 8'hA5, 8'h24, 1'b1, 1'b0);
    chk("c_wrong_out", 32'(out), 32'hA5);
    chk("c_wrong_lane_err", 32'(lane_err), 32'h4);
    chk("c_wrong_err_count", 32'(err_count), 32'h1);
    chk("c_wrong_lane_fault", 32'(lane_fault), 32'h0);

    // Invalid cycle: out holds, lane_err drops
    step(8'h00, 8'hFF, 8'h0F, 1'b0, 1'b0);
    chk("inv_out_hold", 32'(out), 32'hA5);
    chk("inv_valid", 32'(out_valid), 32'h0);
    chk("inv_lane_err", 32'(lane_err), 32'h0);
    chk("inv_err_count", 32'(err_count), 32'h1);

    // Two lanes wrong in the same bits: vote follows the wrong majority
    step(8'hA5, 8'h5A, 8'h5A, 1'b1, 1'b0);
    chk("maj_wrong_out", 32'(out), 32'h5A);
    chk("maj_wrong_lane_err", 32'(lane_err), 32'h1);
    chk("maj_wrong_err_count", 32'(err_count), 32'h2);

    // Lane B wrong on 4 consecutive valid cycles
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("clr1_err_count", 32'(err_count), 32'h0);
    for (int i = 0; i < 3; i++) step(8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0);
    chk("b3_lane_fault", 32'(lane_fault), 32'h0);
    chk("b3_lane_err", 32'(lane_err), 32'h2);
    step(8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0);
    chk("b4_lane_fault", 32'(lane_fault), 32'h2);
    chk("b4_tmr_lost", 32'(tmr_lost), 32'h0);
    chk("b4_err_count", 32'(err_count), 32'h4);
    step(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0);
    chk("b_sticky", 32'(lane_fault), 32'h2);

    // 3 wrong, 1 correct, 3 wrong: run restarts, no fault
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("clr2_lane_fault", 32'(lane_fault), 32'h0);
    for (int i = 0; i < 3; i++) step(8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0);
    step(8'hA5, 8'hA5, 8'hA5, 1'b1, 1'b0);
    chk("b_break_lane_fault", 32'(lane_fault), 32'h0);
    for (int i = 0; i < 3; i++) step(8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0);
    chk("b_restart_lane_fault", 32'(lane_fault), 32'h0);
    chk("b_restart_err_count", 32'(err_count), 32'h6);

    // Invalid cycles inside a run do not break it
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    step(8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0);
    step(8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0);
    step(8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0);
    step(8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0);
    chk("gap3_lane_fault", 32'(lane_fault), 32'h0);
    step(8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0);
    chk("gap4_lane_fault", 32'(lane_fault), 32'h2);

    // Lanes A and C faulty together -> tmr_lost
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 8'hA5, 8'hFF, 1'b1, 1'b0);
    chk("ac3_lane_err", 32'(lane_err), 32'h5);
    chk("ac3_tmr_lost", 32'(tmr_lost), 32'h0);
    step(8'h00, 8'hA5, 8'hFF, 1'b1, 1'b0);
    chk("ac4_out", 32'(out), 32'hA5);
    chk("ac4_lane_fault", 32'(lane_fault), 32'h5);
    chk("ac4_tmr_lost", 32'(tmr_lost), 32'h1);
    chk("ac4_err_count", 32'(err_count), 32'h4);

    // Clear with a same-cycle mismatch: not counted, not tracked
    step(8'hA5, 8'hA5, 8'h24, 1'b1, 1'b1);
    chk("clr_mis_err_count", 32'(err_count), 32'h0);
    chk("clr_mis_lane_fault", 32'(lane_fault), 32'h0);
    chk("clr_mis_tmr_lost", 32'(tmr_lost), 32'h0);
    chk("clr_mis_lane_err", 32'(lane_err), 32'h4);
    for (int i = 0; i < 3; i++) step(8'hA5, 8'hA5, 8'h24, 1'b1, 1'b0);
    chk("clr_untracked_fault", 32'(lane_fault), 32'h0);
    chk("clr_untracked_count", 32'(err_count), 32'h3);

    // Saturation of the 4-bit counter
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) step(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("sat14_err_count", 32'(err_count), 32'hE);
    step(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("sat15_err_count", 32'(err_count), 32'hF);
    for (int i = 0; i < 5; i++) step(8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("sat20_err_count", 32'(err_count), 32'hF);

    // Asynchronous reset mid-run with lane C in SUSPECT
    step(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    step(8'h3C, 8'h3C, 8'hC3, 1'b1, 1'b0);
    step(8'h3C, 8'h3C, 8'hC3, 1'b1, 1'b0);
    chk("pre_rst_lane_err", 32'(lane_err), 32'h4);
    chk("pre_rst_out", 32'(out), 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h3C, 8'h3C, 8'hC3, 1'b1, 1'b0);
    step(8'h3C, 8'h3C, 8'hC3, 1'b1, 1'b0);
    chk("post_rst2_lane_fault", 32'(lane_fault), 32'h0);
    step(8'h3C, 8'h3C, 8'hC3, 1'b1, 1'b0);
    step(8'h3C, 8'h3C, 8'hC3, 1'b1, 1'b0);
    chk("post_rst4_lane_fault", 32'(lane_fault), 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
